// File: rtl/div_repsub_unit.sv
// Sequential unsigned divider: start pulse, then dividend and divisor on data_in.
// Default is repeated subtraction; define DIV_RESTORING_EN for fixed-latency restoring shift-subtract.
module div_repsub_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [2:0] {IDLE, LD_A, LD_B, CHECK, SUB, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

`ifdef DIV_RESTORING_EN
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             qbit;
`endif

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    div_d       = div_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef DIV_RESTORING_EN
    cnt_d   = cnt_q;
    part_d  = part_q;
    // Partial remainder is always < D, so the shifted value needs one extra bit.
    shifted = {part_q, rem_q[WIDTH-1]};
    qbit    = (shifted >= {1'b0, div_q});
    trial   = shifted[WIDTH-1:0] - div_q;
`endif
    case (state_q)
      IDLE: if (start) state_d = LD_A;
      LD_A: begin
        rem_d   = data_in;
        state_d = LD_B;
      end
      LD_B: begin
        div_d   = data_in;
        quo_d   = '0;
        dbz_d   = 1'b0;
`ifdef DIV_RESTORING_EN
        cnt_d   = '0;
        part_d  = '0;
`endif
        state_d = CHECK;
      end
      CHECK: begin
        if (div_q == '0) begin
          quotient_d  = '1;
          remainder_d = rem_q;
          dbz_d       = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = SUB;
        end
      end
      SUB: begin
`ifdef DIV_RESTORING_EN
        part_d = qbit ? trial : shifted[WIDTH-1:0];
        rem_d  = {rem_q[WIDTH-2:0], 1'b0};
        quo_d  = {quo_q[WIDTH-2:0], qbit};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          quotient_d  = quo_d;
          remainder_d = part_d;
          state_d     = DONE;
        end
`else
        if (rem_q >= div_q) begin
          rem_d = rem_q - div_q;
          quo_d = quo_q + 1'b1;
        end else begin
          quotient_d  = quo_q;
          remainder_d = rem_q;
          state_d     = DONE;
        end
`endif
      end
      DONE: if (start) state_d = LD_A;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LD_A) || (state_d == LD_B) || (state_d == CHECK) || (state_d == SUB);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      div_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV_RESTORING_EN
      cnt_q       <= '0;
      part_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DIV_RESTORING_EN
      cnt_q       <= cnt_d;
      part_q      <= part_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_repsub_unit.sv
// Scoreboard bench for div_repsub_unit: expected results queued at launch, checked at done.
// Honours DIV_RESTORING_EN for the expected latency.
module tb_div_repsub_unit;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             busy, done, div_by_zero;
  logic [WIDTH-1:0] quotient, remainder;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  div_repsub_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 3;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
`ifdef DIV_RESTORING_EN
      e.lat = WIDTH + 3;
`else
      e.lat = int'(e.q) + 4;
`endif
    end
    return e;
  endfunction

  // Leaves the bench at the falling edge after edge 1, with the divisor on the bus.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic hold);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = hold; data_in = a;
    @(negedge clk); data_in = b;
    sb.push_back(model(a, b));
  endtask

  task automatic wait_done(input int first_edge, output int lat, output int idle_cyc, output bit ok);
    lat = first_edge; idle_cyc = 0; ok = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin ok = 1'b1; break; end
      if (!busy) idle_cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dbz: got %b expected 0", div_by_zero); end
    vectors++; if ({quotient, remainder} !== '0) begin miscompares++; $display("[TB] FAIL reset_results: got q=%0d r=%0d expected 0/0", quotient, remainder); end
    rst_n = 1'b1;
  endtask

  task automatic test_divide();
    logic [WIDTH-1:0] as [3] = '{16'd100, 16'd5, 16'd12345};
    logic [WIDTH-1:0] bs [3] = '{16'd7, 16'd9, 16'd111};
    int lat, idle; bit ok; exp_t e;
    for (int i = 0; i < 3; i++) begin
      launch(as[i], bs[i], 1'b0);
      wait_done(1, lat, idle, ok);
      e = sb.pop_front();
      vectors++;
      if (!ok) begin miscompares++; $display("[TB] FAIL div_timeout %0d/%0d: done never rose", as[i], bs[i]); continue; end
      vectors++; if (quotient !== e.q) begin miscompares++; $display("[TB] FAIL div_q %0d/%0d: got %0d expected %0d", as[i], bs[i], quotient, e.q); end
      vectors++; if (remainder !== e.r) begin miscompares++; $display("[TB] FAIL div_r %0d/%0d: got %0d expected %0d", as[i], bs[i], remainder, e.r); end
      vectors++; if (div_by_zero !== e.dbz) begin miscompares++; $display("[TB] FAIL div_dbz %0d/%0d: got %b expected %b", as[i], bs[i], div_by_zero, e.dbz); end
      vectors++; if (lat != e.lat) begin miscompares++; $display("[TB] FAIL div_latency %0d/%0d: got edge %0d expected %0d", as[i], bs[i], lat, e.lat); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL div_busy_in_done: got %b expected 0", busy); end
    end
  endtask

  task automatic test_div_by_zero();
    int lat, idle; bit ok; exp_t e;
    launch(16'd500, 16'd0, 1'b0);
    wait_done(1, lat, idle, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL dbz_timeout: done never rose"); return; end
    vectors++; if (quotient !== e.q) begin miscompares++; $display("[TB] FAIL dbz_q: got %0h expected %0h", quotient, e.q); end
    vectors++; if (remainder !== e.r) begin miscompares++; $display("[TB] FAIL dbz_r: got %0d expected %0d", remainder, e.r); end
    vectors++; if (div_by_zero !== 1'b1) begin miscompares++; $display("[TB] FAIL dbz_flag: got %b expected 1", div_by_zero); end
    vectors++; if (lat != 3) begin miscompares++; $display("[TB] FAIL dbz_latency: got edge %0d expected 3", lat); end
    repeat (3) @(negedge clk);
    vectors++; if (done !== 1'b1 || quotient !== e.q) begin miscompares++; $display("[TB] FAIL dbz_hold: got done=%b q=%0h expected done=1 q=%0h", done, quotient, e.q); end
  endtask

  task automatic test_max_dividend();
    int lat, idle; bit ok; exp_t e;
    launch(16'hFFFF, 16'd1, 1'b0);
    wait_done(1, lat, idle, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL max_timeout: done never rose"); return; end
    vectors++; if (quotient !== e.q) begin miscompares++; $display("[TB] FAIL max_q: got %0h expected %0h", quotient, e.q); end
    vectors++; if (remainder !== e.r) begin miscompares++; $display("[TB] FAIL max_r: got %0d expected %0d", remainder, e.r); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("[TB] FAIL max_dbz: got %b expected 0", div_by_zero); end
    vectors++; if (lat != e.lat) begin miscompares++; $display("[TB] FAIL max_latency: got edge %0d expected %0d", lat, e.lat); end
    vectors++; if (idle != 0) begin miscompares++; $display("[TB] FAIL max_busy: got %0d cycles with busy low expected 0", idle); end
  endtask

  task automatic test_reset_mid_op();
    int lat, idle; bit ok; exp_t e;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; data_in = 16'd1000;
    @(negedge clk); data_in = 16'd3;
    repeat (5) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_pre_busy: got %b expected 1", busy); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_flags: got busy=%b done=%b expected 0/0", busy, done); end
    vectors++; if (quotient !== '0 || remainder !== '0) begin miscompares++; $display("[TB] FAIL midrst_results: got q=%0d r=%0d expected 0/0", quotient, remainder); end
    @(negedge clk); rst_n = 1'b1;
    launch(16'd9, 16'd3, 1'b0);
    wait_done(1, lat, idle, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL midrst_timeout: done never rose"); return; end
    vectors++; if (quotient !== e.q || remainder !== e.r) begin miscompares++; $display("[TB] FAIL midrst_after: got q=%0d r=%0d expected q=%0d r=%0d", quotient, remainder, e.q, e.r); end
    vectors++; if (lat != e.lat) begin miscompares++; $display("[TB] FAIL midrst_latency: got edge %0d expected %0d", lat, e.lat); end
  endtask

  task automatic test_back_to_back();
    int lat, idle; bit ok; exp_t e;
    launch(16'd20, 16'd6, 1'b1);
    wait_done(1, lat, idle, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL hold_timeout: done never rose"); start = 1'b0; return; end
    vectors++; if (quotient !== e.q || remainder !== e.r) begin miscompares++; $display("[TB] FAIL hold_result: got q=%0d r=%0d expected q=%0d r=%0d", quotient, remainder, e.q, e.r); end
    vectors++; if (lat != e.lat) begin miscompares++; $display("[TB] FAIL hold_latency: got edge %0d expected %0d", lat, e.lat); end
    // start is still high here, so the next edge launches straight from DONE.
    @(negedge clk);
    vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_busy: got busy=%b done=%b expected 1/0", busy, done); end
    vectors++; if (quotient !== e.q || remainder !== e.r) begin miscompares++; $display("[TB] FAIL b2b_old_held: got q=%0d r=%0d expected q=%0d r=%0d", quotient, remainder, e.q, e.r); end
    start = 1'b0; data_in = 16'd17;
    @(negedge clk); data_in = 16'd4;
    sb.push_back(model(16'd17, 16'd4));
    wait_done(1, lat, idle, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL b2b_timeout: done never rose"); return; end
    vectors++; if (quotient !== e.q || remainder !== e.r) begin miscompares++; $display("[TB] FAIL b2b_result: got q=%0d r=%0d expected q=%0d r=%0d", quotient, remainder, e.q, e.r); end
    vectors++; if (lat != e.lat) begin miscompares++; $display("[TB] FAIL b2b_latency: got edge %0d expected %0d", lat, e.lat); end
    vectors++; if (idle != 0) begin miscompares++; $display("[TB] FAIL b2b_busy_gap: got %0d idle cycles expected 0", idle); end
  endtask

  initial begin
    $display("[TB] starting div_repsub_unit bench");
    test_reset();
    test_divide();
    test_div_by_zero();
    test_max_dividend();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
